// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory target.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] BE_ALL = 4'hF;
    localparam int         CNT_W  = 4;

    // Per-bit write mask from the four byte enables.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] mask;
        if (be == BE_ALL) begin
            mask = '1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                mask[8*b +: 8] = {8{be[b]}};
            end
        end
        return mask;
    endfunction

    // Misaligned, or beyond the last implemented word.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: byte-enable write and combinational read of the same word.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_be,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] w_mask;

    assign w_mask = be_mask(i_be);

    // NOTE: the array has no reset; clearing it would force flops instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wdata & w_mask);
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target with valid/ready request/response and a countdown latency FSM.
// Define DMEM_ERR_CHECK_EN to flag misaligned / out-of-range requests via rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int               AW       = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;

    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;

    logic             w_access;
    logic             w_fault;
    logic             w_mem_we;
    logic [AW-1:0]    w_idx;
    logic [31:0]      w_rd_word;

`ifdef DMEM_ERR_CHECK_EN
    assign w_fault = addr_fault(r_addr, DEPTH_WORDS);
`else
    // Byte offset and upper bits are ignored: addresses wrap modulo the depth.
    logic w_unused_addr;
    assign w_fault       = 1'b0;
    assign w_unused_addr = ^{r_addr[31:AW+2], r_addr[1:0]};
`endif

    // The single array access happens on the WAIT->RESP edge.
    assign w_access = (r_state == WAIT) && (r_cnt == '0);
    assign w_mem_we = w_access && r_we && !w_fault;
    assign w_idx    = r_addr[AW+1:2];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .o_rdata (w_rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_cnt       <= CNT_LOAD;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= (!r_we && !w_fault) ? w_rd_word : 32'h0;
                        r_rsp_err   <= w_fault;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                RESP: begin
                    // Returning through IDLE keeps consume and accept in separate cycles.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random traffic against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [DEPTH];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Present a request and clock it in; request inputs are scrambled afterwards.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        check("ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        check("ready_after_accept", {31'b0, req_ready}, 32'd0);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, LAT);
    endtask

    // Check the held response against the model, hold it, then consume it.
    task automatic expect_rsp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input int hold, output logic [31:0] got);
        logic        err;
        logic [31:0] exp_rdata;
        logic [31:0] w;
        err       = model_err(addr);
        exp_rdata = (we || err) ? 32'h0 : model_mem[widx(addr)];
        if (we && !err) begin
            w = model_mem[widx(addr)];
            for (int b = 0; b < 4; b++) begin
                if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            end
            model_mem[widx(addr)] = w;
        end
        got = rsp_rdata;
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, err});
        check("ready_in_resp", {31'b0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("valid_after_consume", {31'b0, rsp_valid}, 32'd0);
        check("ready_after_consume", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, output logic [31:0] got);
        issue(we, addr, wdata, be);
        wait_rsp();
        expect_rsp(we, addr, wdata, be, hold, got);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic        we;

        foreach (model_mem[i]) model_mem[i] = 32'h0;

        // Reset and idle.
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // rsp_ready with no response pending changes nothing.
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("idle_ready_ignored", {31'b0, req_ready}, 32'd1);
        check("idle_valid_ignored", {31'b0, rsp_valid}, 32'd0);

        // Full-word store then load.
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, got);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        check("load_deadbeef", got, 32'hDEAD_BEEF);

        // Partial byte-enable merge.
        xact(1'b1, 32'h20, 32'h0000_0000, 4'hF, 0, got);
        xact(1'b1, 32'h20, 32'h1122_3344, 4'h5, 0, got);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
        check("load_be_merge", got, 32'h0022_0044);

        // Store with no enables leaves the word alone.
        xact(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, got);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
        check("load_be_zero", got, 32'h0022_0044);

        // Back-pressure: hold 5 cycles while the next request waits.
        issue(1'b1, 32'h30, 32'hA5A5_0F0F, 4'hF);
        wait_rsp();
        req_we    = 1'b0;
        req_addr  = 32'h30;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        req_valid = 1'b1;
        expect_rsp(1'b1, 32'h30, 32'hA5A5_0F0F, 4'hF, 5, got);
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        wait_rsp();
        expect_rsp(1'b0, 32'h30, 32'h0, 4'h0, 0, got);
        check("load_after_hold", got, 32'hA5A5_0F0F);

        // Misaligned store and out-of-range load.
        xact(1'b1, 32'h13, 32'hCAFE_F00D, 4'hF, 0, got);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        xact(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0, got);

        // Reset during WAIT discards the pending store.
        xact(1'b1, 32'h40, 32'h1234_5678, 4'hF, 0, got);
        issue(1'b1, 32'h40, 32'h8765_4321, 4'hF);
        rst = 1'b0;
        #1;
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'h0);
        check("midrst_rsp_err", {31'b0, rsp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_held_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        xact(1'b0, 32'h40, 32'h0, 4'h0, 0, got);
        check("load_after_midrst", got, 32'h1234_5678);

        // Random traffic over a small window, with occasional misaligned or wrapped addresses.
        for (int k = 0; k < 60; k++) begin
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            case ($urandom_range(0, 7))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = a + 32'(4 * DEPTH);
                default: ;
            endcase
            we = ($urandom_range(0, 1) == 1);
            xact(we, a, $urandom, 4'($urandom), $urandom_range(0, 2), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
